// File: rtl/mio_pkg.sv
// rtl/mio_pkg.sv - shared address map, control bit indices and bus FSM states for mio_bus
package mio_pkg;

    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] LED_ADDR    = 32'hE000_0000;
    localparam logic [31:0] SW_ADDR     = 32'hE000_0004;
    localparam logic [31:0] CNT_ADDR    = 32'hF000_0000;
    localparam logic [31:0] CTRL_ADDR   = 32'hF000_0004;
    localparam logic [31:0] RELOAD_ADDR = 32'hF000_0008;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_PEND = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAM_RD = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/mio_timer.sv
// rtl/mio_timer.sv - 32-bit down-counter with reload, auto-restart and sticky pending flag
module mio_timer
    import mio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cnt_we,
    input  logic        ctrl_we,
    input  logic        reload_we,
    input  logic        pend_clr,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] reload,
    output logic        en,
    output logic        auto_reload,
    output logic        pend
);

    logic expire;
    assign expire = en && (count == 32'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count       <= 32'd0;
            reload      <= 32'd0;
            en          <= 1'b0;
            auto_reload <= 1'b0;
            pend        <= 1'b0;
        end else begin
            // A CPU write to the count register takes priority over the timer's own update.
            if (cnt_we) begin
                count <= wdata;
            end else if (en) begin
                if (count != 32'd0) begin
                    count <= count - 32'd1;
                end else if (auto_reload) begin
                    count <= reload;
                end
            end

            if (ctrl_we) begin
                en          <= wdata[CTRL_EN];
                auto_reload <= wdata[CTRL_AUTO];
            end else if (expire && !auto_reload) begin
                en <= 1'b0;
            end

            if (reload_we) begin
                reload <= wdata;
            end

            // Expiry wins over a simultaneous clear so an interrupt is never lost.
            if (expire) begin
                pend <= 1'b1;
            end else if (pend_clr) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mio_bus.sv
// rtl/mio_bus.sv - CPU data-port decoder and access FSM for RAM, GPIO and timer targets
module mio_bus
    import mio_pkg::*;
#(
    parameter int RAM_ADDR_W = 10,
    parameter int SW_W       = 16,
    parameter int LED_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_mem_w,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_ready,
    output logic                  cpu_int,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    output logic                  ram_we,
    input  logic [31:0]           ram_rdata,
    input  logic [SW_W-1:0]       sw_in,
    output logic [LED_W-1:0]      led_out
);

    state_t      state;
    logic [29:0] word;
    logic        hit_ram, hit_led, hit_sw, hit_cnt, hit_ctrl, hit_reload;
    logic        start, wr;
    logic [31:0] rd_data;
    logic [31:0] count, reload;
    logic        en, auto_reload, pend;
    logic        unused_addr_bits;

    assign word             = cpu_addr[31:2];
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign hit_ram    = (cpu_addr[31:RAM_ADDR_W+2] == RAM_BASE[31:RAM_ADDR_W+2]);
    assign hit_led    = (word == LED_ADDR[31:2]);
    assign hit_sw     = (word == SW_ADDR[31:2]);
    assign hit_cnt    = (word == CNT_ADDR[31:2]);
    assign hit_ctrl   = (word == CTRL_ADDR[31:2]);
    assign hit_reload = (word == RELOAD_ADDR[31:2]);

    // The RAM registers its address, so it must see the request in the first cycle.
    assign start     = reset && (state == IDLE) && cpu_req;
    assign wr        = start && cpu_mem_w;
    assign ram_we    = wr && hit_ram;
    assign ram_addr  = (start && hit_ram) ? cpu_addr[RAM_ADDR_W+1:2] : '0;
    assign ram_wdata = ram_we ? cpu_wdata : 32'd0;
    assign cpu_int   = pend;

    always_comb begin
        rd_data = 32'd0;
        if (hit_led)         rd_data = 32'(led_out);
        else if (hit_sw)     rd_data = 32'(sw_in);
        else if (hit_cnt)    rd_data = count;
        else if (hit_ctrl)   rd_data = 32'({pend, auto_reload, en});
        else if (hit_reload) rd_data = reload;
    end

    mio_timer u_timer (
        .clk         (clk),
        .reset       (reset),
        .cnt_we      (wr && hit_cnt),
        .ctrl_we     (wr && hit_ctrl),
        .reload_we   (wr && hit_reload),
        .pend_clr    (wr && hit_ctrl && cpu_wdata[CTRL_PEND]),
        .wdata       (cpu_wdata),
        .count       (count),
        .reload      (reload),
        .en          (en),
        .auto_reload (auto_reload),
        .pend        (pend)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cpu_ready <= 1'b0;
            cpu_rdata <= 32'd0;
            led_out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cpu_ready <= 1'b0;
                    if (cpu_req) begin
                        if (hit_ram && !cpu_mem_w) begin
                            state <= RAM_RD;
                        end else begin
                            state     <= RESP;
                            cpu_ready <= 1'b1;
                            if (!cpu_mem_w) begin
                                cpu_rdata <= rd_data;
                            end else if (hit_led) begin
                                led_out <= cpu_wdata[LED_W-1:0];
                            end
                        end
                    end
                end
                RAM_RD: begin
                    cpu_rdata <= ram_rdata;
                    cpu_ready <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    cpu_ready <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    cpu_ready <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mio_bus.sv
// tb/tb_mio_bus.sv - directed self-checking bench for mio_bus with a behavioural RAM
module tb_mio_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_mem_w;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_int;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic [15:0] sw_in;
    logic [15:0] led_out;

    logic [31:0] mem [0:1023];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    mio_bus dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_mem_w (cpu_mem_w),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_int   (cpu_int),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .sw_in     (sw_in),
        .led_out   (led_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One CPU access; returns at the negedge of the cpu_ready cycle with cpu_req dropped.
    task automatic access(input logic w, input logic [31:0] addr, input logic [31:0] data,
                          output logic [31:0] rdata, output int lat,
                          output int we_cnt, output logic [31:0] we_addr);
        @(posedge clk);
        #1;
        cpu_req   = 1'b1;
        cpu_mem_w = w;
        cpu_addr  = addr;
        cpu_wdata = data;
        lat = 0;
        we_cnt = 0;
        we_addr = 32'd0;
        @(negedge clk);
        if (ram_we) begin
            we_cnt++;
            we_addr = 32'(ram_addr);
        end
        while (lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ram_we) we_cnt++;
            if (cpu_ready) break;
        end
        rdata     = cpu_rdata;
        cpu_req   = 1'b0;
        cpu_mem_w = 1'b0;
        check("ready_seen", 32'(cpu_ready), 32'd1);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        int lat, wc;
        logic [31:0] wa;
        access(1'b1, addr, data, rd, lat, wc, wa);
        check("wr_latency", 32'(lat), 32'd1);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data, output int lat);
        int wc;
        logic [31:0] wa;
        access(1'b0, addr, 32'd0, data, lat, wc, wa);
        check("rd_no_ram_we", 32'(wc), 32'd0);
    endtask

    initial begin
        logic [31:0] data;
        int lat, wc;
        logic [31:0] wa;
        logic seen;

        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        reset = 1'b0;
        cpu_req = 1'b0;
        cpu_mem_w = 1'b0;
        cpu_addr = 32'd0;
        cpu_wdata = 32'd0;
        sw_in = 16'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(cpu_ready), 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_int", 32'(cpu_int), 32'd0);
        check("rst_led", 32'(led_out), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | cpu_ready;
        end
        check("idle_no_ready", 32'(seen), 32'd0);

        // RAM write then read-back
        access(1'b1, 32'h0000_0010, 32'h1234_5678, data, lat, wc, wa);
        check("ram_wr_latency", 32'(lat), 32'd1);
        check("ram_we_pulses", 32'(wc), 32'd1);
        check("ram_we_addr", wa, 32'd4);
        rd(32'h0000_0010, data, lat);
        check("ram_rd_data", data, 32'h1234_5678);
        check("ram_rd_latency", 32'(lat), 32'd2);

        // GPIO and unmapped
        wr(32'hE000_0000, 32'h0000_A5A5);
        check("led_out", 32'(led_out), 32'h0000_A5A5);
        sw_in = 16'h00F0;
        rd(32'hE000_0004, data, lat);
        check("sw_rd", data, 32'h0000_00F0);
        check("sw_rd_latency", 32'(lat), 32'd1);
        rd(32'h8000_0000, data, lat);
        check("unmapped_rd", data, 32'd0);
        check("unmapped_latency", 32'(lat), 32'd1);
        wr(32'hE000_0004, 32'h0000_FFFF);
        rd(32'hE000_0000, data, lat);
        check("led_rd", data, 32'h0000_A5A5);

        // Auto-reload timer: PEND visible 4 cycles after the CTRL write completes
        wr(32'hF000_0008, 32'd3);
        wr(32'hF000_0000, 32'd3);
        wr(32'hF000_0004, 32'h3);
        check("auto_t1", 32'(cpu_int), 32'd0);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            check("auto_first", 32'(cpu_int), (k == 5) ? 32'd1 : 32'd0);
        end
        wr(32'hF000_0004, 32'h7);
        check("auto_w1c", 32'(cpu_int), 32'd0);
        @(negedge clk);
        check("auto_t8", 32'(cpu_int), 32'd0);
        @(negedge clk);
        check("auto_repeat", 32'(cpu_int), 32'd1);
        wr(32'hF000_0004, 32'h4);
        check("stop_clear", 32'(cpu_int), 32'd0);
        repeat (6) @(negedge clk);
        check("stop_stays_clear", 32'(cpu_int), 32'd0);
        rd(32'hF000_0000, data, lat);
        check("stop_count", data, 32'd1);
        rd(32'hF000_0004, data, lat);
        check("stop_ctrl", data, 32'd0);

        // One-shot timer
        wr(32'hF000_0000, 32'd2);
        wr(32'hF000_0004, 32'h1);
        check("oneshot_s1", 32'(cpu_int), 32'd0);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            check("oneshot_pend", 32'(cpu_int), (k == 4) ? 32'd1 : 32'd0);
        end
        rd(32'hF000_0004, data, lat);
        check("oneshot_ctrl", data, 32'h4);
        rd(32'hF000_0000, data, lat);
        check("oneshot_count", data, 32'd0);

        // W1C landing in the expiry cycle loses to the expiry
        wr(32'hF000_0004, 32'h4);
        check("pre_clear", 32'(cpu_int), 32'd0);
        wr(32'hF000_0000, 32'd2);
        wr(32'hF000_0004, 32'h1);
        @(negedge clk);
        wr(32'hF000_0004, 32'h4);
        check("w1c_vs_expiry", 32'(cpu_int), 32'd1);
        rd(32'hF000_0004, data, lat);
        check("w1c_vs_expiry_ctrl", data, 32'h4);

        // Reset during RAM_RD abandons the read
        @(posedge clk);
        #1;
        cpu_req = 1'b1;
        cpu_mem_w = 1'b0;
        cpu_addr = 32'h0000_0010;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", 32'(cpu_ready), 32'd0);
        check("mid_rst_ram_we", 32'(ram_we), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cpu_req = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | cpu_ready;
        end
        check("mid_rst_no_ready", 32'(seen), 32'd0);
        check("mid_rst_led", 32'(led_out), 32'd0);
        check("mid_rst_int", 32'(cpu_int), 32'd0);
        rd(32'h0000_0010, data, lat);
        check("post_rst_rd", data, 32'h1234_5678);
        check("post_rst_latency", 32'(lat), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
